// File: rtl/wbtracemon.sv
// rtl/wbtracemon.sv - passive Wishbone B4 pipelined trace monitor emitting one record per completed transaction
// Optional request timeout is compiled in when WBTRACEMON_TIMEOUT_EN is defined.
module wbtracemon #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16,
    parameter int TIDBITS  = 13,
    parameter int LATBITS  = 8,
    parameter int DEPTH    = 32,
    parameter int TIMEOUT  = 200,
    parameter int DROPBITS = 8
) (
    input  logic                i_wb_clk,
    input  logic                i_wb_rst,
    input  logic [ADDRBITS-1:0] i_wb_adr,
    input  logic [DATABITS-1:0] i_wb_dat_m,
    input  logic                i_wb_we,
    input  logic                i_wb_stb,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stall,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    input  logic [DATABITS-1:0] i_wb_dat_s,
    input  logic                i_dbg_en,
    input  logic [ADDRBITS-1:0] i_flt_adr,
    input  logic [ADDRBITS-1:0] i_flt_mask,
    input  logic [1:0]          i_flt_we,
    output logic                o_dbg_stb,
    input  logic                i_dbg_rdy,
    output logic [2+TIDBITS+1+ADDRBITS+2*DATABITS+LATBITS-1:0] o_dbg_txn,
    output logic [DROPBITS-1:0] o_drop_cnt,
    output logic                o_desync
);

    localparam int BUSBITS = 2 + TIDBITS + 1 + ADDRBITS + 2 * DATABITS + LATBITS;
    localparam int AW      = $clog2(DEPTH);
    localparam int EW      = 1 + TIDBITS + 1 + ADDRBITS + DATABITS + LATBITS;

    localparam logic [1:0] ST_ACK = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_TMO = 2'd2;

`ifdef WBTRACEMON_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic [LATBITS-1:0] ts;
    logic [TIDBITS-1:0] tid;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [EW-1:0]      mem [DEPTH];

    logic               accept;
    logic               any_resp;
    logic               resp;
    logic               empty;
    logic               full;
    logic               we_ok;
    logic               keep_new;
    logic [EW-1:0]      new_entry;

    logic [EW-1:0]      head;
    logic               head_keep;
    logic [TIDBITS-1:0] head_tid;
    logic               head_we;
    logic [ADDRBITS-1:0] head_adr;
    logic [DATABITS-1:0] head_dat_m;
    logic [LATBITS-1:0] head_ts;
    logic [LATBITS-1:0] head_lat;

    logic               bypass;
    logic               pop_resp;
    logic               timeout;
    logic               pop;
    logic               push;
    logic               overflow;
    logic [1:0]         resp_status;

    logic               rec_valid;
    logic [BUSBITS-1:0] rec;

    assign accept   = i_wb_cyc & i_wb_stb & ~i_wb_stall;
    assign any_resp = i_wb_ack | i_wb_err;
    assign resp     = i_wb_cyc & any_resp;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_comb begin
        we_ok = 1'b0;
        case (i_flt_we)
            2'd0:    we_ok = 1'b1;
            2'd1:    we_ok = ~i_wb_we;
            2'd2:    we_ok = i_wb_we;
            default: we_ok = 1'b0;
        endcase
    end

    assign keep_new  = i_dbg_en && (((i_wb_adr ^ i_flt_adr) & i_flt_mask) == '0) && we_ok;
    assign new_entry = {keep_new, tid, i_wb_we, i_wb_adr, i_wb_dat_m, ts};

    assign head = mem[rd_ptr[AW-1:0]];
    assign {head_keep, head_tid, head_we, head_adr, head_dat_m, head_ts} = head;
    assign head_lat = ts - head_ts;

    // err outranks ack when a slave raises both in one cycle
    assign resp_status = i_wb_err ? ST_ERR : ST_ACK;

    // A desynchronised pipeline is frozen until the master ends the cycle
    assign bypass   = empty & accept & resp & ~o_desync;
    assign pop_resp = ~empty & resp & ~o_desync;
    assign timeout  = TO_EN & ~empty & i_wb_cyc & ~any_resp & ~o_desync
                      & (head_lat >= LATBITS'(TIMEOUT));
    assign pop      = pop_resp | timeout;
    assign push     = accept & ~bypass & ~o_desync & (~full | pop);
    assign overflow = accept & ~bypass & ~o_desync & full & ~pop;

    always_comb begin
        rec_valid = 1'b0;
        rec       = '0;
        if (bypass) begin
            rec_valid = keep_new;
            rec       = {resp_status, tid, i_wb_we, i_wb_adr, i_wb_dat_m, i_wb_dat_s, {LATBITS{1'b0}}};
        end else if (pop_resp) begin
            rec_valid = head_keep;
            rec       = {resp_status, head_tid, head_we, head_adr, head_dat_m, i_wb_dat_s, head_lat};
        end else if (timeout) begin
            rec_valid = head_keep;
            rec       = {ST_TMO, head_tid, head_we, head_adr, head_dat_m, {DATABITS{1'b0}}, head_lat};
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst && push) begin
            mem[wr_ptr[AW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            ts       <= '0;
            tid      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_desync <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (accept) begin
                tid <= tid + 1'b1;
            end
            if (!i_wb_cyc) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                o_desync <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (overflow || timeout) begin
                    o_desync <= 1'b1;
                end
            end
        end
    end

    // Output holding register: a record that finds it occupied and not draining is lost
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_dbg_stb  <= 1'b0;
            o_dbg_txn  <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (o_dbg_stb && i_dbg_rdy) begin
                o_dbg_stb <= 1'b0;
            end
            if (rec_valid) begin
                if (!o_dbg_stb || i_dbg_rdy) begin
                    o_dbg_stb <= 1'b1;
                    o_dbg_txn <= rec;
                end else if (o_drop_cnt != {DROPBITS{1'b1}}) begin
                    o_drop_cnt <= o_drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wbtracemon.sv
// tb/tb_wbtracemon.sv - directed and randomized self-checking bench for wbtracemon against a queue-based model
module tb_wbtracemon;

    localparam int ADDRBITS = 26;
    localparam int DATABITS = 16;
    localparam int TIDBITS  = 13;
    localparam int LATBITS  = 8;
    localparam int DEPTH    = 32;
    localparam int TIMEOUT  = 10;
    localparam int DROPBITS = 8;
    localparam int BUSBITS  = 2 + TIDBITS + 1 + ADDRBITS + 2 * DATABITS + LATBITS;

`ifdef WBTRACEMON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [ADDRBITS-1:0] adr;
    logic [DATABITS-1:0] dat_m;
    logic                we;
    logic                stb;
    logic                cyc;
    logic                stall;
    logic                ack;
    logic                err;
    logic [DATABITS-1:0] dat_s;
    logic                dbg_en;
    logic [ADDRBITS-1:0] flt_adr;
    logic [ADDRBITS-1:0] flt_mask;
    logic [1:0]          flt_we;
    logic                dbg_stb;
    logic                dbg_rdy;
    logic [BUSBITS-1:0]  dbg_txn;
    logic [DROPBITS-1:0] drop_cnt;
    logic                desync;

    wbtracemon #(
        .ADDRBITS(ADDRBITS), .DATABITS(DATABITS), .TIDBITS(TIDBITS), .LATBITS(LATBITS),
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DROPBITS(DROPBITS)
    ) dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat_m(dat_m), .i_wb_we(we),
        .i_wb_stb(stb), .i_wb_cyc(cyc), .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
        .i_wb_dat_s(dat_s), .i_dbg_en(dbg_en), .i_flt_adr(flt_adr), .i_flt_mask(flt_mask),
        .i_flt_we(flt_we), .o_dbg_stb(dbg_stb), .i_dbg_rdy(dbg_rdy), .o_dbg_txn(dbg_txn),
        .o_drop_cnt(drop_cnt), .o_desync(desync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                keep;
        logic [TIDBITS-1:0]  tid;
        logic                we;
        logic [ADDRBITS-1:0] adr;
        logic [DATABITS-1:0] datm;
        logic [LATBITS-1:0]  ts;
    } pend_t;

    pend_t               pend[$];
    logic [BUSBITS-1:0]  log_q[$];
    logic [LATBITS-1:0]  m_ts;
    logic [TIDBITS-1:0]  m_tid;
    logic                m_desync;
    logic                m_stb;
    logic [BUSBITS-1:0]  m_txn;
    logic [DROPBITS-1:0] m_drop;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic keep_of();
        logic mode_ok;
        mode_ok = (flt_we == 2'd0) || (flt_we == 2'd1 && !we) || (flt_we == 2'd2 && we);
        return dbg_en && (((adr ^ flt_adr) & flt_mask) == '0) && mode_ok;
    endfunction

    task automatic model_edge();
        logic acc, anyr, resp, rec_v, old_stb;
        logic [BUSBITS-1:0] rec;
        logic [LATBITS-1:0] dl;
        logic [1:0] st;
        pend_t n, h;
        if (rst) begin
            m_ts = '0; m_tid = '0; pend.delete(); m_desync = 1'b0;
            m_stb = 1'b0; m_txn = '0; m_drop = '0;
            return;
        end
        acc   = cyc && stb && !stall;
        anyr  = ack || err;
        resp  = cyc && anyr;
        st    = err ? 2'd1 : 2'd0;
        rec_v = 1'b0;
        rec   = '0;
        n = '{keep: keep_of(), tid: m_tid, we: we, adr: adr, datm: dat_m, ts: m_ts};
        if (!cyc) begin
            pend.delete();
            m_desync = 1'b0;
        end else if (!m_desync) begin
            if (pend.size() == 0 && acc && resp) begin
                rec_v = n.keep;
                rec   = {st, n.tid, n.we, n.adr, n.datm, dat_s, 8'd0};
            end else begin
                if (resp && pend.size() > 0) begin
                    h = pend.pop_front();
                    dl = m_ts - h.ts;
                    rec_v = h.keep;
                    rec   = {st, h.tid, h.we, h.adr, h.datm, dat_s, dl};
                end else if (TO_EN && pend.size() > 0 && !anyr) begin
                    dl = m_ts - pend[0].ts;
                    if (int'(dl) >= TIMEOUT) begin
                        h = pend.pop_front();
                        rec_v = h.keep;
                        rec   = {2'd2, h.tid, h.we, h.adr, h.datm, 16'd0, dl};
                        m_desync = 1'b1;
                    end
                end
                if (acc) begin
                    if (pend.size() >= DEPTH) m_desync = 1'b1;
                    else pend.push_back(n);
                end
            end
        end
        if (acc) m_tid = m_tid + 1'b1;
        m_ts = m_ts + 1'b1;
        old_stb = m_stb;
        if (m_stb && dbg_rdy) m_stb = 1'b0;
        if (rec_v) begin
            if (!old_stb || dbg_rdy) begin
                m_stb = 1'b1;
                m_txn = rec;
            end else if (m_drop != 8'hFF) begin
                m_drop = m_drop + 1'b1;
            end
        end
    endtask

    task automatic tick();
        if (dbg_stb && dbg_rdy) log_q.push_back(dbg_txn);
        @(posedge clk);
        model_edge();
        #1;
        chk("stb", 128'(dbg_stb), 128'(m_stb));
        chk("desync", 128'(desync), 128'(m_desync));
        chk("drop", 128'(drop_cnt), 128'(m_drop));
        if (m_stb) chk("txn", 128'(dbg_txn), 128'(m_txn));
    endtask

    task automatic bus(input logic c, input logic s, input logic w, input logic [ADDRBITS-1:0] a,
                       input logic [DATABITS-1:0] dm, input logic ak, input logic er,
                       input logic [DATABITS-1:0] ds);
        cyc = c; stb = s; stall = 1'b0; we = w; adr = a; dat_m = dm; ack = ak; err = er; dat_s = ds;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    initial begin
        bit found;
        dbg_en = 1'b1; flt_adr = '0; flt_mask = '0; flt_we = 2'd0; dbg_rdy = 1'b1;
        do_reset();
        chk("rst_stb", 128'(dbg_stb), 128'(0));
        chk("rst_txn", 128'(dbg_txn), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        chk("rst_desync", 128'(desync), 128'(0));

        // single read acked three cycles after acceptance
        bus(1, 1, 0, 26'h100, 16'h1111, 0, 0, 16'h0); tick();
        bus(1, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0); tick(); tick();
        bus(1, 0, 0, 26'h0, 16'h0, 1, 0, 16'hBEEF); tick();
        chk("t1_stb", 128'(dbg_stb), 128'(1));
        chk("t1_status", 128'(dbg_txn[81:80]), 128'(0));
        chk("t1_tid", 128'(dbg_txn[79:67]), 128'(0));
        chk("t1_adr", 128'(dbg_txn[65:40]), 128'(26'h100));
        chk("t1_dats", 128'(dbg_txn[23:8]), 128'(16'hBEEF));
        chk("t1_lat", 128'(dbg_txn[7:0]), 128'(3));

        // bypass, then four pipelined writes acked in order
        do_reset();
        bus(1, 1, 1, 26'h200, 16'h2222, 1, 0, 16'h3333); tick();
        chk("t2_byp_stb", 128'(dbg_stb), 128'(1));
        chk("t2_byp_lat", 128'(dbg_txn[7:0]), 128'(0));
        for (int i = 0; i < 4; i++) begin
            bus(1, 1, 1, 26'h300 + 26'(i), 16'h4000 + 16'(i), 0, 0, 16'h0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus(1, 0, 0, 26'h0, 16'h0, 1, 0, 16'h5000 + 16'(i)); tick();
            chk("t2_tid", 128'(dbg_txn[79:67]), 128'(i + 1));
            chk("t2_we", 128'(dbg_txn[66]), 128'(1));
        end

        // address filter keeps only matching requests, pairing stays intact
        do_reset();
        flt_mask = 26'h3FFFFFF; flt_adr = 26'h10;
        bus(1, 1, 0, 26'h10, 16'h0, 0, 0, 16'h0); tick();
        bus(1, 1, 0, 26'h20, 16'h0, 0, 0, 16'h0); tick();
        bus(1, 1, 0, 26'h10, 16'h0, 0, 0, 16'h0); tick();
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, 0, 26'h0, 16'h0, 1, 0, 16'hA0 + 16'(i)); tick();
        end
        bus(1, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0); tick(); tick();
        chk("t3_count", 128'(log_q.size()), 128'(2));
        if (log_q.size() == 2) begin
            chk("t3_tid0", 128'(log_q[0][79:67]), 128'(0));
            chk("t3_dat0", 128'(log_q[0][23:8]), 128'(16'hA0));
            chk("t3_tid1", 128'(log_q[1][79:67]), 128'(2));
            chk("t3_dat1", 128'(log_q[1][23:8]), 128'(16'hA2));
        end
        flt_mask = '0; flt_adr = '0;

        // backpressure: first record held, later ones dropped
        do_reset();
        dbg_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(1, 1, 0, 26'h40, 16'h0, 1, 0, 16'hC0 + 16'(i)); tick();
        end
        bus(1, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0); tick();
        chk("t4_held", 128'(dbg_stb), 128'(1));
        chk("t4_tid", 128'(dbg_txn[79:67]), 128'(0));
        chk("t4_drop", 128'(drop_cnt), 128'(2));
        dbg_rdy = 1'b1; tick();
        chk("t4_consumed", 128'(dbg_stb), 128'(0));

        // overflow desyncs until the cycle ends
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus(1, 1, 0, 26'(i), 16'h0, 0, 0, 16'h0); tick();
        end
        chk("t5_desync", 128'(desync), 128'(1));
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, 0, 26'h0, 16'h0, 1, 0, 16'h77); tick();
            chk("t5_norec", 128'(dbg_stb), 128'(0));
        end
        bus(0, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0); tick();
        chk("t5_clear", 128'(desync), 128'(0));
        bus(1, 1, 0, 26'h5, 16'h0, 1, 0, 16'h88); tick();
        chk("t5_empty_byp", 128'(dbg_stb), 128'(1));
        chk("t5_tid", 128'(dbg_txn[79:67]), 128'(DEPTH + 1));

`ifdef WBTRACEMON_TIMEOUT_EN
        do_reset();
        bus(1, 1, 0, 26'h99, 16'h0, 0, 0, 16'h0); tick();
        bus(1, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = dbg_stb;
        end
        chk("t6_found", 128'(found), 128'(1));
        chk("t6_status", 128'(dbg_txn[81:80]), 128'(2));
        chk("t6_lat", 128'(dbg_txn[7:0]), 128'(TIMEOUT));
        chk("t6_desync", 128'(desync), 128'(1));
        bus(0, 0, 0, 26'h0, 16'h0, 0, 0, 16'h0); tick();
`endif

        // err wins over ack, both bypassed and queued
        do_reset();
        bus(1, 1, 0, 26'h11, 16'h0, 1, 1, 16'h1); tick();
        chk("t7_byp_err", 128'(dbg_txn[81:80]), 128'(1));
        bus(1, 1, 0, 26'h12, 16'h0, 0, 0, 16'h0); tick();
        bus(1, 0, 0, 26'h0, 16'h0, 1, 1, 16'h2); tick();
        chk("t7_q_err", 128'(dbg_txn[81:80]), 128'(1));
        chk("t7_q_lat", 128'(dbg_txn[7:0]), 128'(1));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            cyc      = ($urandom_range(0, 39) != 0);
            stb      = $urandom_range(0, 1) == 1;
            stall    = ($urandom_range(0, 3) == 0);
            we       = $urandom_range(0, 1) == 1;
            adr      = 26'($urandom_range(0, 7));
            dat_m    = 16'($urandom);
            ack      = ($urandom_range(0, 9) < 4);
            err      = ($urandom_range(0, 9) == 0);
            dat_s    = 16'($urandom);
            dbg_en   = ($urandom_range(0, 9) != 0);
            flt_adr  = 26'($urandom_range(0, 7));
            flt_mask = 26'($urandom_range(0, 3));
            flt_we   = 2'($urandom_range(0, 3));
            dbg_rdy  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
